// File: rtl/scan_pkg.sv
// Shared types for the CPU state scanner: sweep states, entry kinds and the
// reference entry layout for the default widths.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN_RF,
        SCAN_MEM,
        FINISH
    } scan_state_t;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    localparam int SCAN_IDX_W  = 8;
    localparam int SCAN_DATA_W = 32;
    localparam int PC_W        = 32;

    // Bit order matches the packed {kind, index, data} word the scanner pushes.
    typedef struct packed {
        logic                   kind;
        logic [SCAN_IDX_W-1:0]  index;
        logic [SCAN_DATA_W-1:0] data;
    } scan_entry_t;

endpackage

// File: rtl/scan_fifo.sv
// Synchronous-write, combinational-read FIFO. Pointers carry one extra wrap
// bit so full and empty can be told apart when the indices match.
module scan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] storage [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = storage[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) storage[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cpu_state_scanner.sv
// Debug sweeper: holds the CPU, walks every register then a memory window and
// queues each value for a valid/ready consumer. SCAN_PC_TAG_EN adds out_pc.
module cpu_state_scanner
    import scan_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int RF_ADDR_W  = 5,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 8,
    parameter int IDX_W      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    mem_base,
    output logic [RF_ADDR_W-1:0] rf_addr,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    rf_data,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic [31:0]          cpu_pc,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_kind,
`ifdef SCAN_PC_TAG_EN
    output logic [31:0]          out_pc,
`endif
    output logic [IDX_W-1:0]     out_index
);

`ifdef SCAN_PC_TAG_EN
    localparam int FIFO_W = PC_W + 1 + IDX_W + DATA_W;
`else
    localparam int FIFO_W = 1 + IDX_W + DATA_W;
`endif

    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);

    scan_state_t       state;
    scan_state_t       next_state;
    logic [ADDR_W-1:0] base_addr;
    logic [IDX_W-1:0]  idx;
    logic              last_entry;
    logic              push;
    logic              push_kind;
    logic [DATA_W-1:0] push_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;

`ifdef SCAN_PC_TAG_EN
    logic [PC_W-1:0]   pc_tag;
    logic              unused_inputs;
    assign unused_inputs = ^mem_base[1:0];
`else
    logic              unused_inputs;
    assign unused_inputs = ^{cpu_pc, mem_base[1:0]};
`endif

    assign last_entry = (state == SCAN_MEM) ? (idx == LAST_MEM) : (idx == LAST_REG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // A phase only ends on a cycle whose final entry actually entered the FIFO.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = SCAN_RF;
            SCAN_RF:  if (!fifo_full && last_entry) next_state = SCAN_MEM;
            SCAN_MEM: if (!fifo_full && last_entry) next_state = FINISH;
            FINISH:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        cpu_hold  = 1'b0;
        done      = 1'b0;
        push      = 1'b0;
        push_kind = KIND_REG;
        push_data = rf_data;
        case (state)
            SCAN_RF: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                push     = !fifo_full;
            end
            SCAN_MEM: begin
                busy      = 1'b1;
                cpu_hold  = 1'b1;
                push      = !fifo_full;
                push_kind = KIND_MEM;
                push_data = mem_data;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    // Addresses advance only with a successful push, so a full FIFO freezes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_addr   <= '0;
            mem_addr  <= '0;
            base_addr <= '0;
            idx       <= '0;
`ifdef SCAN_PC_TAG_EN
            pc_tag    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_addr <= {mem_base[ADDR_W-1:2], 2'b00};
                        rf_addr   <= '0;
                        idx       <= '0;
`ifdef SCAN_PC_TAG_EN
                        pc_tag    <= cpu_pc;
`endif
                    end
                end
                SCAN_RF: begin
                    if (!fifo_full) begin
                        if (last_entry) begin
                            rf_addr  <= '0;
                            idx      <= '0;
                            mem_addr <= base_addr;
                        end else begin
                            rf_addr <= rf_addr + RF_ADDR_W'(1);
                            idx     <= idx + IDX_W'(1);
                        end
                    end
                end
                SCAN_MEM: begin
                    if (!fifo_full) begin
                        if (last_entry) begin
                            mem_addr <= '0;
                            idx      <= '0;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(4);
                            idx      <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    rf_addr  <= '0;
                    mem_addr <= '0;
                end
            endcase
        end
    end

`ifdef SCAN_PC_TAG_EN
    assign fifo_din = {pc_tag, push_kind, idx, push_data};
    assign {out_pc, out_kind, out_index, out_data} = fifo_dout;
`else
    assign fifo_din = {push_kind, idx, push_data};
    assign {out_kind, out_index, out_data} = fifo_dout;
`endif

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    scan_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
